// File: rtl/onfi_host_pkg.sv
// Shared definitions for the ONFI SDR host sequencer: op codes, FSM states,
// timing counter width and the counter preload helper.
package onfi_host_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        OP_CE_REL  = 3'd0,
        OP_CMD     = 3'd1,
        OP_ADDR    = 3'd2,
        OP_WR      = 3'd3,
        OP_RD      = 3'd4,
        OP_WAIT_RB = 3'd5,
        OP_SET_WP  = 3'd6,
        OP_RSVD    = 3'd7
    } op_code_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WE_LO   = 3'd1;
    localparam logic [2:0] S_WE_HI   = 3'd2;
    localparam logic [2:0] S_RE_LO   = 3'd3;
    localparam logic [2:0] S_RE_HI   = 3'd4;
    localparam logic [2:0] S_WB_WAIT = 3'd5;
    localparam logic [2:0] S_RB_WAIT = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_WE_LO   = S_WE_LO,
        ST_WE_HI   = S_WE_HI,
        ST_RE_LO   = S_RE_LO,
        ST_RE_HI   = S_RE_HI,
        ST_WB_WAIT = S_WB_WAIT,
        ST_RB_WAIT = S_RB_WAIT
    } state_t;

    // A phase of t cycles preloads t-1; zero is treated as a one-cycle phase.
    function automatic logic [CNT_W-1:0] cnt_load(input int t);
        if (t <= 1)
            return '0;
        return CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/onfi_rb_sync.sv
// Two-flop synchroniser for the asynchronous NAND ready/busy pin.
// Resets to 1 (ready) so a freshly reset host never sees a false busy.
module onfi_rb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rb_n_async,
    output logic rb_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            rb_sync <= 1'b1;
        end else begin
            meta    <= rb_n_async;
            rb_sync <= meta;
        end
    end

endmodule

// File: rtl/onfi_sdr_host_seq.sv
// ONFI SDR (asynchronous-mode) host bus sequencer: turns a stream of bus ops into
// pin-level cycles. Optional R/B busy timeout enabled by macro ONFI_RB_TIMEOUT_EN.
module onfi_sdr_host_seq
    import onfi_host_pkg::*;
#(
    parameter int T_WP           = 2,
    parameter int T_WH           = 2,
    parameter int T_RP           = 2,
    parameter int T_REH          = 2,
    parameter int T_WB           = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [7:0] op_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rb_timeout,
    output logic       CE_x_n,
    output logic       CLE_x,
    output logic       ALE_x,
    output logic       WE_x_n,
    output logic       RE_x_n,
    output logic       WP_x_n,
    output logic [7:0] io_out,
    output logic       io_oe,
    input  logic [7:0] io_in,
    input  logic       RB_x_n
);

    localparam logic [CNT_W-1:0] WP_LD  = cnt_load(T_WP);
    localparam logic [CNT_W-1:0] WH_LD  = cnt_load(T_WH);
    localparam logic [CNT_W-1:0] RP_LD  = cnt_load(T_RP);
    localparam logic [CNT_W-1:0] REH_LD = cnt_load(T_REH);
    localparam logic [CNT_W-1:0] WB_LD  = cnt_load(T_WB);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rb_sync;
    logic             to_hit;

    onfi_rb_sync u_rb_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rb_n_async (RB_x_n),
        .rb_sync    (rb_sync)
    );

`ifdef ONFI_RB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    // Counts cycles spent in RB_WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_RB_WAIT)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 16'd1;
    end

    assign to_hit = (to_cnt == TO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rb_timeout <= 1'b0;
            CE_x_n     <= 1'b1;
            CLE_x      <= 1'b0;
            ALE_x      <= 1'b0;
            WE_x_n     <= 1'b1;
            RE_x_n     <= 1'b1;
            WP_x_n     <= 1'b0;
            io_out     <= '0;
            io_oe      <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            rb_timeout <= 1'b0;
            case (state)
                // Single-cycle ops stay in IDLE and spend their one busy cycle with op_ready low.
                ST_IDLE: begin
                    if (!op_ready) begin
                        op_ready <= 1'b1;
                    end else if (op_valid) begin
                        op_ready <= 1'b0;
                        case (op_code_t'(op_code))
                            OP_CMD, OP_ADDR, OP_WR: begin
                                CE_x_n <= 1'b0;
                                CLE_x  <= (op_code_t'(op_code) == OP_CMD);
                                ALE_x  <= (op_code_t'(op_code) == OP_ADDR);
                                io_out <= op_data;
                                io_oe  <= 1'b1;
                                WE_x_n <= 1'b0;
                                cnt    <= WP_LD;
                                state  <= ST_WE_LO;
                            end
                            OP_RD: begin
                                CE_x_n <= 1'b0;
                                io_oe  <= 1'b0;
                                RE_x_n <= 1'b0;
                                cnt    <= RP_LD;
                                state  <= ST_RE_LO;
                            end
                            OP_WAIT_RB: begin
                                cnt   <= WB_LD;
                                state <= ST_WB_WAIT;
                            end
                            OP_CE_REL: CE_x_n <= 1'b1;
                            OP_SET_WP: WP_x_n <= op_data[0];
                            default: ;
                        endcase
                    end
                end
                ST_WE_LO: begin
                    if (cnt == '0) begin
                        WE_x_n <= 1'b1;
                        cnt    <= WH_LD;
                        state  <= ST_WE_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WE_HI: begin
                    if (cnt == '0) begin
                        CLE_x    <= 1'b0;
                        ALE_x    <= 1'b0;
                        io_oe    <= 1'b0;
                        op_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RE_LO: begin
                    if (cnt == '0) begin
                        rd_data  <= io_in;
                        rd_valid <= 1'b1;
                        RE_x_n   <= 1'b1;
                        cnt      <= REH_LD;
                        state    <= ST_RE_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RE_HI: begin
                    if (cnt == '0) begin
                        op_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WB_WAIT: begin
                    if (cnt == '0)
                        state <= ST_RB_WAIT;
                    else
                        cnt <= cnt - 1'b1;
                end
                // Ready wins over a timeout that expires in the same cycle.
                ST_RB_WAIT: begin
                    if (rb_sync) begin
                        op_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (to_hit) begin
                        rb_timeout <= 1'b1;
                        op_ready   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onfi_sdr_host_seq.sv
// Self-checking bench for onfi_sdr_host_seq: per-cycle pin expectations derived
// from op timing rules, with randomized op/data/io/R-B stimulus.
module tb_onfi_sdr_host_seq;

    localparam int T_WP  = 2;
    localparam int T_WH  = 2;
    localparam int T_RP  = 3;
    localparam int T_REH = 2;
    localparam int T_WB  = 4;
    localparam int TO    = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] op_code = '0;
    logic [7:0] op_data = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rb_timeout;
    logic       CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n;
    logic [7:0] io_out;
    logic       io_oe;
    logic [7:0] io_in = '0;
    logic       RB_x_n = 1'b1;

    int total = 0;
    int bad = 0;

    // Reference model of the persistent pin state between ops.
    logic       m_ce = 1'b1;
    logic       m_wp = 1'b0;
    logic [7:0] m_io = '0;
    logic [7:0] m_rd = '0;

    localparam logic [25:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

    always #5 clk = ~clk;

    onfi_sdr_host_seq #(
        .T_WP(T_WP), .T_WH(T_WH), .T_RP(T_RP), .T_REH(T_REH), .T_WB(T_WB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .rb_timeout(rb_timeout), .CE_x_n(CE_x_n), .CLE_x(CLE_x), .ALE_x(ALE_x),
        .WE_x_n(WE_x_n), .RE_x_n(RE_x_n), .WP_x_n(WP_x_n), .io_out(io_out),
        .io_oe(io_oe), .io_in(io_in), .RB_x_n(RB_x_n)
    );

    function automatic logic [25:0] observed();
        return {CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n, io_oe, op_ready,
                rd_valid, rb_timeout, io_out, rd_data};
    endfunction

    function automatic bit is_we_op(input logic [2:0] code);
        return (code == 3'd1) || (code == 3'd2) || (code == 3'd3);
    endfunction

    function automatic int op_len(input logic [2:0] code);
        if (is_we_op(code)) return T_WP + T_WH;
        if (code == 3'd4)   return T_RP + T_REH;
        return 1;
    endfunction

    // Expected pins in cycle i after accept (i = op_len+1 is the following IDLE cycle).
    function automatic logic [25:0] exp_op(input logic [2:0] code, input logic [7:0] data,
                                           input logic [7:0] rb, input int i);
        logic ce, cle, ale, we, re, wp, oe, rdy, rv;
        logic [7:0] io, rd;
        ce = m_ce; cle = 0; ale = 0; we = 1; re = 1; wp = m_wp; oe = 0; rdy = 0; rv = 0;
        io = m_io; rd = m_rd;
        if (is_we_op(code)) begin ce = 0; io = data; end
        if (code == 3'd4) ce = 0;
        if (code == 3'd0) ce = 1;
        if (code == 3'd6) wp = data[0];
        if (i > op_len(code)) begin
            rdy = 1;
        end else begin
            if (is_we_op(code)) begin
                cle = (code == 3'd1); ale = (code == 3'd2); oe = 1; we = (i > T_WP);
            end
            if (code == 3'd4) re = (i > T_RP);
        end
        if (code == 3'd4 && i > T_RP) rd = rb;
        if (code == 3'd4 && i == T_RP + 1) rv = 1;
        return {ce, cle, ale, we, re, wp, oe, rdy, rv, 1'b0, io, rd};
    endfunction

    function automatic void commit(input logic [2:0] code, input logic [7:0] data, input logic [7:0] rb);
        if (is_we_op(code)) begin m_ce = 0; m_io = data; end
        if (code == 3'd4) begin m_ce = 0; m_rd = rb; end
        if (code == 3'd0) m_ce = 1;
        if (code == 3'd6) m_wp = data[0];
    endfunction

    function automatic void model_reset();
        m_ce = 1; m_wp = 0; m_io = '0; m_rd = '0;
    endfunction

    // Presents one op and returns at the first negedge after it was accepted.
    task automatic issue(input logic [2:0] code, input logic [7:0] data, input logic [7:0] rb);
        int guard = 0;
        while (op_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (op_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready got=%b want=1", op_ready);
        end
        op_valid = 1'b1; op_code = code; op_data = data; io_in = rb;
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'($urandom); op_data = 8'($urandom);
    endtask

    task automatic test_reset();
        logic [25:0] got;
        rst_n = 1'b0;
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        got = observed();
        total++;
        if (got !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", got, RESET_VEC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (op_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", op_ready);
        end
    endtask

    task automatic test_cmd();
        logic [25:0] got, exp;
        issue(3'd1, 8'h00, 8'($urandom));
        for (int i = 1; i <= op_len(3'd1) + 1; i++) begin
            if (i > 1) @(negedge clk);
            got = observed(); exp = exp_op(3'd1, 8'h00, io_in, i);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL cmd cyc=%0d got=%h want=%h", i, got, exp);
            end
        end
        commit(3'd1, 8'h00, io_in);
    endtask

    task automatic test_addr_burst();
        logic [25:0] got, exp;
        logic [7:0] addrs [5] = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h01};
        logic [7:0] rb;
        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom);
            issue(3'd2, addrs[k], rb);
            for (int i = 1; i <= op_len(3'd2) + 1; i++) begin
                if (i > 1) @(negedge clk);
                got = observed(); exp = exp_op(3'd2, addrs[k], rb, i);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL addr k=%0d cyc=%0d got=%h want=%h", k, i, got, exp);
                end
                // Next request is held pending while busy; it must not be taken early.
                if (i == 1 && k < 4) begin
                    op_valid = 1'b1; op_code = 3'd2; op_data = addrs[k+1];
                end
            end
            commit(3'd2, addrs[k], rb);
        end
    endtask

    task automatic test_read(input logic [7:0] rb);
        logic [25:0] got, exp;
        issue(3'd4, ~rb, rb);
        io_in = ~rb;
        for (int i = 1; i <= op_len(3'd4) + 1; i++) begin
            if (i > 1) @(negedge clk);
            got = observed(); exp = exp_op(3'd4, 8'h00, rb, i);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL read cyc=%0d got=%h want=%h", i, got, exp);
            end
            if (i == T_RP) io_in = rb;
            if (i == T_RP + 1) io_in = 8'($urandom);
        end
        commit(3'd4, 8'h00, rb);
    endtask

    // r: cycle after accept at whose negedge RB_x_n rises (0 = already high).
    task automatic test_wait_rb(input int r);
        logic [25:0] got, exp;
        int e_rb, e_to, e;
        bit to;
        e_rb = (r + 3 > T_WB + 2) ? r + 3 : T_WB + 2;
`ifdef ONFI_RB_TIMEOUT_EN
        e_to = T_WB + TO + 1;
`else
        e_to = 1 << 30;
`endif
        to = (e_to < e_rb);
        e = to ? e_to : e_rb;
        if (r > 0) RB_x_n = 1'b0;
        issue(3'd5, 8'($urandom), 8'($urandom));
        for (int i = 1; i <= e + 1; i++) begin
            if (i > 1) @(negedge clk);
            got = observed();
            exp = {m_ce, 1'b0, 1'b0, 1'b1, 1'b1, m_wp, 1'b0, (i >= e), 1'b0, (to && i == e), m_io, m_rd};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL wait_rb r=%0d cyc=%0d got=%h want=%h", r, i, got, exp);
            end
            if (i == r) RB_x_n = 1'b1;
        end
        RB_x_n = 1'b1;
    endtask

    task automatic test_timeout();
`ifdef ONFI_RB_TIMEOUT_EN
        test_wait_rb(200);
`else
        test_wait_rb(60);
`endif
    endtask

    task automatic test_reset_mid_op();
        logic [25:0] got, exp;
        issue(3'd3, 8'hA5, 8'h00);
        got = observed(); exp = exp_op(3'd3, 8'hA5, 8'h00, 1);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL wr_before_reset got=%h want=%h", got, exp);
        end
        rst_n = 1'b0;
        @(negedge clk);
        got = observed();
        total++;
        if (got !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_mid_wr got=%h want=%h", got, RESET_VEC);
        end
        rst_n = 1'b1;
        model_reset();
        issue(3'd4, 8'h00, 8'hC3);
        repeat (T_RP - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        got = observed();
        total++;
        if (got !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_mid_rd got=%h want=%h", got, RESET_VEC);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_wp_ce();
        logic [25:0] got, exp;
        logic [2:0] codes [4] = '{3'd6, 3'd1, 3'd7, 3'd0};
        logic [7:0] datas [4] = '{8'h01, 8'hFF, 8'h3C, 8'h00};
        for (int k = 0; k < 4; k++) begin
            issue(codes[k], datas[k], 8'h00);
            for (int i = 1; i <= op_len(codes[k]) + 1; i++) begin
                if (i > 1) @(negedge clk);
                got = observed(); exp = exp_op(codes[k], datas[k], 8'h00, i);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL wp_ce k=%0d cyc=%0d got=%h want=%h", k, i, got, exp);
                end
            end
            commit(codes[k], datas[k], 8'h00);
        end
    endtask

    task automatic test_random();
        logic [25:0] got, exp;
        logic [2:0] code;
        logic [7:0] data, rb;
        for (int n = 0; n < 40; n++) begin
            code = 3'($urandom_range(0, 7));
            data = 8'($urandom);
            rb   = 8'($urandom);
            if (code == 3'd5) begin
                test_wait_rb(int'($urandom_range(0, 12)));
            end else begin
                issue(code, data, rb);
                for (int i = 1; i <= op_len(code) + 1; i++) begin
                    if (i > 1) @(negedge clk);
                    got = observed(); exp = exp_op(code, data, rb, i);
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL random n=%0d op=%0d cyc=%0d got=%h want=%h", n, code, i, got, exp);
                    end
                end
                commit(code, data, rb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_addr_burst();
        test_read(8'h5A);
        test_read(8'($urandom));
        test_wait_rb(20);
        test_wait_rb(0);
        test_wait_rb(2);
        test_timeout();
        test_reset_mid_op();
        test_wp_ce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
